// File: rtl/alu_md_pkg.sv
// Shared constants for the alu_md block.
//   NOPS         : number of one-hot ALU op bits
//   OP_*         : bit index of each ALU op inside alu_ctrl
//   md_op_e      : multiply/divide operation encodings
//   md_state_e   : multiply/divide engine states
package alu_md_pkg;

    localparam int unsigned NOPS    = 10;

    localparam int unsigned OP_ADDU = 0;
    localparam int unsigned OP_SUBU = 1;
    localparam int unsigned OP_ADD  = 2;
    localparam int unsigned OP_SUB  = 3;
    localparam int unsigned OP_AND  = 4;
    localparam int unsigned OP_OR   = 5;
    localparam int unsigned OP_XOR  = 6;
    localparam int unsigned OP_NOR  = 7;
    localparam int unsigned OP_SLT  = 8;
    localparam int unsigned OP_SLTU = 9;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdRun  = 2'd1,
        MdFix  = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_md_md_unit.sv
// Sequential multiply/divide engine with HI/LO registers.
// Operands are captured on the accepting edge, WIDTH iterations follow (shift-add multiply or
// restoring divide on magnitudes), then one sign-correction cycle writes HI/LO and pulses md_done.
//   clk, rst        : clock, asynchronous active-high reset
//   md_start, md_op : launch request and operation (MULT/MULTU/DIV/DIVU)
//   a, b            : operands; a is also the MTHI/MTLO write data
//   hi_we, lo_we    : MTHI/MTLO strobes, honoured only while idle and not starting
//   md_busy         : high from acceptance until the result is written
//   md_done         : one-cycle pulse, HI/LO just updated
//   hi, lo          : HI/LO registers
module md_unit
    import alu_md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: product high half / partial remainder; quo: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] bm_q, bm_d;      // |b|
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;    // negate product / quotient
    logic             rneg_q, rneg_d;  // negate remainder
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             op_signed;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        bm_d     = bm_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        mul_sum  = {1'b0, acc_q} + {1'b0, (quo_q[0] ? bm_q : '0)};
        rem_sh   = {acc_q, quo_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, bm_q};
        prod     = {acc_q, quo_q};
        prod_fix = neg_q ? -prod : prod;

        unique case (state_q)
            MdIdle: begin
                if (md_start) begin
                    state_d  = MdRun;
                    cnt_d    = '0;
                    acc_d    = '0;
                    quo_d    = (op_signed && a[WIDTH-1]) ? -a : a;
                    bm_d     = (op_signed && b[WIDTH-1]) ? -b : b;
                    is_div_d = md_op[1];
                    neg_d    = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d   = op_signed && a[WIDTH-1];
                end else begin
                    if (hi_we) hi_d = a;
                    if (lo_we) lo_d = a;
                end
            end
            MdRun: begin
                if (is_div_q) begin
                    // Trial fits in WIDTH bits whenever it is non-negative, so bit WIDTH is the sign.
                    if (!trial[WIDTH]) begin
                        acc_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MdFix;
            end
            MdFix: begin
                if (is_div_q) begin
                    lo_d = neg_q ? -quo_q : quo_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MdIdle;
            end
            default: state_d = MdIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MdIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            bm_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            bm_q     <= bm_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign md_busy = (state_q != MdIdle);
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU with one-hot op select plus a sequential multiply/divide unit.
//   a, b, shamt, alu_ctrl : ALU operands, shift amount (reserved), one-hot op select
//   c, overflow, zero     : combinational result, signed ADD/SUB overflow, c == 0
//   md_* , hi_we, lo_we   : multiply/divide handshake and MTHI/MTLO strobes
//   hi, lo                : HI/LO registers
module alu_md #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned NOPS    = alu_md_pkg::NOPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [NOPS-1:0]    alu_ctrl,
    output logic [WIDTH-1:0]   c,
    output logic               overflow,
    output logic               zero,
    input  logic               md_start,
    input  logic [1:0]         md_op,
    output logic               md_busy,
    output logic               md_done,
    input  logic               hi_we,
    input  logic               lo_we,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    import alu_md_pkg::*;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             sltu;
    logic             add_ovf;
    logic             sub_ovf;
    logic             unused_shamt;

    // Reserved for future shift op bits.
    assign unused_shamt = ^shamt;

    assign sum  = a + b;
    assign diff = a - b;
    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        c = '0;
        if (alu_ctrl[OP_ADDU]) c = c | sum;
        if (alu_ctrl[OP_SUBU]) c = c | diff;
        if (alu_ctrl[OP_ADD])  c = c | sum;
        if (alu_ctrl[OP_SUB])  c = c | diff;
        if (alu_ctrl[OP_AND])  c = c | (a & b);
        if (alu_ctrl[OP_OR])   c = c | (a | b);
        if (alu_ctrl[OP_XOR])  c = c | (a ^ b);
        if (alu_ctrl[OP_NOR])  c = c | ~(a | b);
        if (alu_ctrl[OP_SLT])  c = c | {{(WIDTH-1){1'b0}}, slt};
        if (alu_ctrl[OP_SLTU]) c = c | {{(WIDTH-1){1'b0}}, sltu};
    end

    assign overflow = (alu_ctrl[OP_ADD] & add_ovf) | (alu_ctrl[OP_SUB] & sub_ovf);
    assign zero     = (c == '0);

    md_unit #(
        .WIDTH(WIDTH)
    ) u_md_unit (
        .clk     (clk),
        .rst     (rst),
        .md_start(md_start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .md_busy (md_busy),
        .md_done (md_done),
        .hi      (hi),
        .lo      (lo)
    );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed and random ALU checks, and a scoreboard for the
// multiply/divide unit whose monitor pops an expected {hi,lo} on every md_done.
module tb_alu_md;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0, b = '0;
    logic [4:0]    shamt = '0;
    logic [9:0]    alu_ctrl = '0;
    logic [W-1:0]  c;
    logic          overflow, zero;
    logic          md_start = 1'b0;
    logic [1:0]    md_op = '0;
    logic          md_busy, md_done;
    logic          hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    alu_md dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .shamt(shamt), .alu_ctrl(alu_ctrl),
        .c(c), .overflow(overflow), .zero(zero), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .md_done(md_done), .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic logic [63:0] md_model(input logic [1:0] op, input logic [31:0] x,
                                             input logic [31:0] y);
        longint sx, sy;
        logic [63:0] ux, uy;
        logic [31:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (op)
            2'd0: return 64'(sx * sy);
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 0) begin
                    q = (sx < 0) ? 32'd1 : 32'hFFFFFFFF;
                    r = x;
                end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    q = x;
                    r = 32'd0;
                end else begin
                    q = 32'(sx / sy);
                    r = 32'(sx % sy);
                end
            end
            default: begin
                if (y == 0) begin
                    q = 32'hFFFFFFFF;
                    r = x;
                end else begin
                    q = x / y;
                    r = x % y;
                end
            end
        endcase
        return {r, q};
    endfunction

    task automatic alu_chk(input int idx, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] e;
        logic        ov;
        longint      s;
        ov = 1'b0;
        case (idx)
            0, 2: e = x + y;
            1, 3: e = x - y;
            4: e = x & y;
            5: e = x | y;
            6: e = x ^ y;
            7: e = ~(x | y);
            8: e = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: e = (x < y) ? 32'd1 : 32'd0;
        endcase
        if (idx == 2) s = longint'($signed(x)) + longint'($signed(y));
        else          s = longint'($signed(x)) - longint'($signed(y));
        if ((idx == 2 || idx == 3) && (s > 64'sd2147483647 || s < -64'sd2147483648)) ov = 1'b1;
        @(negedge clk);
        a = x;
        b = y;
        alu_ctrl = 10'(1 << idx);
        #1;
        chk($sformatf("alu_c op%0d", idx), 64'(c), 64'(e));
        chk($sformatf("alu_ovf op%0d", idx), 64'(overflow), 64'(ov));
        chk($sformatf("alu_zero op%0d", idx), 64'(zero), 64'(e == 0));
    endtask

    // inj: 0 none, 1 second start mid-run, 2 lo_we mid-run, 3 hi_we with the start
    task automatic md_run(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int inj);
        logic [63:0] r;
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = m_hi;
        old_lo = m_lo;
        r = md_model(op, x, y);
        @(negedge clk);
        alu_ctrl = '0;
        a = x;
        b = y;
        md_op = op;
        md_start = 1'b1;
        if (inj == 3) hi_we = 1'b1;
        sb.push_back(r);
        m_hi = r[63:32];
        m_lo = r[31:0];
        @(negedge clk);
        md_start = 1'b0;
        hi_we = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            if (inj == 3 && n == 1) chk("start_hi_we_drop", 64'(hi), 64'(old_hi));
            if (n == 5 && inj == 1) begin
                md_start = 1'b1;
                md_op = ~op;
            end
            if (n == 5 && inj == 2) lo_we = 1'b1;
            if (n == 6) begin
                md_start = 1'b0;
                lo_we = 1'b0;
                if (inj == 2) chk("lo_we_busy", 64'(lo), 64'(old_lo));
            end
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(W + 1));
        chk("done_pulse", 64'(md_done), 64'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got md_done=1 expected 0");
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("md_hi", 64'(hi), 64'(e[63:32]));
                chk("md_lo", 64'(lo), 64'(e[31:0]));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed ALU cases
        alu_chk(2, 32'h7FFFFFFF, 32'd1);
        alu_chk(0, 32'h7FFFFFFF, 32'd1);
        alu_chk(3, 32'd0, 32'd1);
        alu_chk(3, 32'h80000000, 32'd1);
        alu_chk(8, 32'hFFFFFFFF, 32'd1);
        alu_chk(9, 32'hFFFFFFFF, 32'd1);
        alu_chk(7, 32'd0, 32'd0);
        alu_chk(1, 32'd5, 32'd5);
        @(negedge clk);
        alu_ctrl = '0;
        a = 32'h12345678;
        b = 32'h9ABCDEF0;
        #1;
        chk("alu_none_c", 64'(c), 64'd0);
        chk("alu_none_zero", 64'(zero), 64'd1);
        for (int i = 0; i < 30; i++) alu_chk(i % 10, $urandom, $urandom);

        // Directed multiply/divide
        md_run(2'd0, 32'hFFFFFFFD, 32'd7, 0);
        md_run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        md_run(2'd2, 32'hFFFFFFF9, 32'd2, 0);
        md_run(2'd3, 32'd7, 32'd0, 0);
        md_run(2'd2, 32'hFFFFFFF9, 32'd0, 0);
        md_run(2'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        md_run(2'd0, 32'h80000000, 32'h80000000, 0);

        // MTHI / MTLO while idle
        @(negedge clk);
        a = 32'hDEADBEEF;
        hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        m_hi = 32'hDEADBEEF;
        chk("mthi", 64'(hi), 64'(m_hi));
        a = 32'h0BADF00D;
        lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        m_lo = 32'h0BADF00D;
        chk("mtlo", 64'(lo), 64'(m_lo));

        // Events while busy / same-edge start with hi_we
        md_run(2'd1, 32'd1234567, 32'd89, 1);
        md_run(2'd3, 32'd1000, 32'd7, 2);
        md_run(2'd1, 32'h55AA55AA, 32'd0, 3);

        // Random multiply/divide
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            md_run(2'($urandom_range(0, 3)), x, y, 0);
        end

        // Reset part-way through a DIVU
        @(negedge clk);
        a = 32'hFFFF0000;
        b = 32'd3;
        md_op = 2'd3;
        md_start = 1'b1;
        sb.push_back(md_model(2'd3, 32'hFFFF0000, 32'd3));
        @(negedge clk);
        md_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        chk("abort_busy", 64'(md_busy), 64'd0);
        chk("abort_done", 64'(md_done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        md_run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
